// File: rtl/f2s_req_tx.sv
// Fast-to-slow control-pulse transmitter: queues adat pulses and issues one
// four-phase req/ack handshake per pulse. Optional ack watchdog: ACK_TIMEOUT_EN.
module f2s_req_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             adat,
  input  logic             ack,
  output logic             req,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] pend,
  output logic             ovf,
  output logic             err_to
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACKLOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   launch;
  logic                   sat;
  logic [CNT_W-1:0]       pend_nx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the shift chain a real synchroniser.
  always_ff @(posedge aclk) begin
    if (!rst) ack_sync <= '0;
    else      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = IDLE;
    launch   = 1'b0;
    case (state)
      IDLE: begin
        if (adat || (pend != '0)) begin
          state_nx = REQ;
          launch   = 1'b1;
        end
      end
      REQ:     state_nx = ack_s ? ACKLOW : REQ;
      ACKLOW:  state_nx = ack_s ? ACKLOW : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A pulse that launches directly never touches the queue; a full queue drops it.
  always_comb begin
    pend_nx = pend;
    sat     = 1'b0;
    if (adat && !launch) begin
      if (pend == PEND_MAX) sat     = 1'b1;
      else                  pend_nx = pend + 1'b1;
    end else if (!adat && launch) begin
      pend_nx = pend - 1'b1;
    end
  end

  // req/busy come straight from flops fed by next-state, so they never glitch.
  always_ff @(posedge aclk) begin
    if (!rst) begin
      state <= IDLE;
      req   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      req   <= (state_nx == REQ);
      done  <= (state == ACKLOW) && !ack_s;
      busy  <= (state_nx != IDLE) || (pend_nx != '0);
      pend  <= pend_nx;
      if (sat) ovf <= 1'b1;
    end
  end

`ifdef ACK_TIMEOUT_EN
  localparam int               TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;

  // Counts REQ cycles; flags once the count reaches TIMEOUT, never aborts.
  always_ff @(posedge aclk) begin
    if (!rst) begin
      to_cnt <= '0;
      err_to <= 1'b0;
    end else if (launch) begin
      to_cnt <= '0;
    end else if ((state == REQ) && (to_cnt != TO_MAX)) begin
      to_cnt <= to_cnt + 1'b1;
      if (!ack_s && (to_cnt == TO_LAST)) err_to <= 1'b1;
    end
  end
`else
  assign err_to = 1'b0;
`endif

endmodule
